timx_ic_input_stage: RTL

- Per-channel input-capture front end that sits directly upstream of the timer core's capture/compare and slave-mode logic.
- Synchronises a raw channel pin (timx_chN_in) into the timer clock domain, applies the ICF digital filter and the CCP/CCNP polarity selection, and detects edges.
- Applies the ICPS capture prescaler and produces the single-cycle capture strobe that latches CCRx and sets CCxIF.
- One instance per channel (4 total).
- The filtered and polarity-selected levels also feed the TI1F_ED/TI1FP1/TI2FP2 trigger mux.

---
 rtl/timx_ic_input_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/timx_ic_input_stage.sv
// Per-channel input-capture front end: pin synchroniser, ICF digital filter,
// polarity select, edge detect and ICPS capture prescaler.
module timx_ic_input_stage #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       apb_clk,
  input  logic       apb_rst_n,
  input  logic       ch_in,
  input  logic [3:0] cfg_icf,
  input  logic       cfg_ccp,
  input  logic       cfg_ccnp,
  input  logic [1:0] cfg_icps,
  input  logic       cfg_cce,
  output logic       tixf,
  output logic       tixfp,
  output logic       tixf_ed,
  output logic       ic_edge,
  output logic       ic_cap
);

  localparam int unsigned SYNC_W = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned DIV_W  = 5;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PSC_W  = 3;

  logic [SYNC_W-1:0] sync_q;
  logic              in_s;

  logic [3:0]        icf_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_nxt;
  logic [DIV_W-1:0]  div_max;
  logic [CNT_W-1:0]  mcnt_q;
  logic [CNT_W-1:0]  mcnt_nxt;
  logic [CNT_W-1:0]  mcnt_max;
  logic              icf_chg;
  logic              sample_en;
  logic              tixf_nxt;

  logic              tixf_dly;
  logic              active_edge;

  logic [1:0]        icps_q;
  logic              cce_q;
  logic [PSC_W-1:0]  pcnt_q;
  logic [PSC_W-1:0]  pcnt_nxt;
  logic [PSC_W-1:0]  pcnt_max;
  logic              psc_clr;
  logic              cap_nxt;

  assign in_s = sync_q[SYNC_W-1];

  // ICxF decode: div_max = D-1, mcnt_max = N-1
  always_comb begin
    div_max  = DIV_W'(0);
    mcnt_max = CNT_W'(0);
    case (icf_q)
      4'b0001: begin div_max = DIV_W'(0);  mcnt_max = CNT_W'(1); end
      4'b0010: begin div_max = DIV_W'(0);  mcnt_max = CNT_W'(3); end
      4'b0011: begin div_max = DIV_W'(0);  mcnt_max = CNT_W'(7); end
      4'b0100: begin div_max = DIV_W'(1);  mcnt_max = CNT_W'(5); end
      4'b0101: begin div_max = DIV_W'(1);  mcnt_max = CNT_W'(7); end
      4'b0110: begin div_max = DIV_W'(3);  mcnt_max = CNT_W'(5); end
      4'b0111: begin div_max = DIV_W'(3);  mcnt_max = CNT_W'(7); end
      4'b1000: begin div_max = DIV_W'(7);  mcnt_max = CNT_W'(5); end
      4'b1001: begin div_max = DIV_W'(7);  mcnt_max = CNT_W'(7); end
      4'b1010: begin div_max = DIV_W'(15); mcnt_max = CNT_W'(4); end
      4'b1011: begin div_max = DIV_W'(15); mcnt_max = CNT_W'(5); end
      4'b1100: begin div_max = DIV_W'(15); mcnt_max = CNT_W'(7); end
      4'b1101: begin div_max = DIV_W'(31); mcnt_max = CNT_W'(4); end
      4'b1110: begin div_max = DIV_W'(31); mcnt_max = CNT_W'(5); end
      4'b1111: begin div_max = DIV_W'(31); mcnt_max = CNT_W'(7); end
      default: begin div_max = DIV_W'(0);  mcnt_max = CNT_W'(0); end
    endcase
  end

  assign icf_chg   = (cfg_icf != icf_q);
  assign sample_en = (div_q == div_max);

  // Filter: a new level is accepted only after N consecutive differing samples
  always_comb begin
    div_nxt  = div_q;
    mcnt_nxt = mcnt_q;
    tixf_nxt = tixf;
    if (icf_chg) begin
      div_nxt  = DIV_W'(0);
      mcnt_nxt = CNT_W'(0);
    end else if (icf_q == 4'b0000) begin
      div_nxt  = DIV_W'(0);
      mcnt_nxt = CNT_W'(0);
      tixf_nxt = in_s;
    end else begin
      div_nxt = sample_en ? DIV_W'(0) : DIV_W'(div_q + DIV_W'(1));
      if (sample_en) begin
        if (in_s != tixf) begin
          if (mcnt_q == mcnt_max) begin
            tixf_nxt = in_s;
            mcnt_nxt = CNT_W'(0);
          end else begin
            mcnt_nxt = CNT_W'(mcnt_q + CNT_W'(1));
          end
        end else begin
          mcnt_nxt = CNT_W'(0);
        end
      end
    end
  end

  // Active-edge select; ccp=0/ccnp=1 is reserved and behaves as rising
  always_comb begin
    case ({cfg_ccp, cfg_ccnp})
      2'b11:   active_edge = tixf ^ tixf_dly;
      2'b10:   active_edge = ~tixf & tixf_dly;
      default: active_edge = tixf & ~tixf_dly;
    endcase
  end

  always_comb begin
    case (cfg_icps)
      2'b00:   pcnt_max = PSC_W'(0);
      2'b01:   pcnt_max = PSC_W'(1);
      2'b10:   pcnt_max = PSC_W'(3);
      default: pcnt_max = PSC_W'(7);
    endcase
  end

  // Disabled, just-enabled or ratio-changing cycles flush the prescaler
  assign psc_clr = ~cfg_cce | ~cce_q | (cfg_icps != icps_q);

  always_comb begin
    pcnt_nxt = pcnt_q;
    cap_nxt  = 1'b0;
    if (psc_clr) begin
      pcnt_nxt = PSC_W'(0);
    end else if (ic_edge) begin
      if (pcnt_q == pcnt_max) begin
        pcnt_nxt = PSC_W'(0);
        cap_nxt  = 1'b1;
      end else begin
        pcnt_nxt = PSC_W'(pcnt_q + PSC_W'(1));
      end
    end
  end

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      sync_q   <= '0;
      icf_q    <= 4'b0000;
      div_q    <= DIV_W'(0);
      mcnt_q   <= CNT_W'(0);
      tixf     <= 1'b0;
      tixfp    <= 1'b0;
      tixf_dly <= 1'b0;
      tixf_ed  <= 1'b0;
      ic_edge  <= 1'b0;
      icps_q   <= 2'b00;
      cce_q    <= 1'b0;
      pcnt_q   <= PSC_W'(0);
      ic_cap   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_W-2:0], ch_in};
      icf_q    <= cfg_icf;
      div_q    <= div_nxt;
      mcnt_q   <= mcnt_nxt;
      tixf     <= tixf_nxt;
      tixfp    <= tixf_nxt ^ (cfg_ccp & ~cfg_ccnp);
      tixf_dly <= tixf;
      tixf_ed  <= tixf ^ tixf_dly;
      ic_edge  <= active_edge;
      icps_q   <= cfg_icps;
      cce_q    <= cfg_cce;
      pcnt_q   <= pcnt_nxt;
      ic_cap   <= cap_nxt;
    end
  end

endmodule
